// File: rtl/sa_pkg.sv
// Shared types and the output clamp/wrap helper for the systolic matmul array.
package sa_pkg;
  localparam int DW_DEF   = 16;
  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;
  localparam int AW_DEF   = 2*DW_DEF + $clog2(ROWS_DEF) + 1;
  localparam int LAT      = ROWS_DEF + COLS_DEF;

  typedef logic signed [DW_DEF-1:0] data_t;
  typedef logic signed [AW_DEF-1:0] acc_t;

  // Reduce a wide signed sum to dw bits: clamp when sat, else keep the low dw bits (sign-extended).
  function automatic logic signed [63:0] sat_f(input logic signed [63:0] v, input int dw,
                                                input bit sat);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw-1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (!sat) return (v <<< (64-dw)) >>> (64-dw);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/sa_pe.sv
// One weight-stationary MAC cell: A passes right, partial sum passes down.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 35
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 w_load,
  input  logic signed [DW-1:0] w_in,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [AW-1:0] psum_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [AW-1:0] psum_out
);
  logic signed [DW-1:0]   w;
  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a_in) * (2*DW)'(w);

  // Weight load is independent of en: swaps only happen with the array drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w <= w_in;
      if (en) begin
        a_out    <= a_in;
        psum_out <= psum_in + AW'(prod);
      end
    end
  end
endmodule

// File: rtl/sa_stream_array.sv
// ROWS x COLS weight-stationary systolic matmul with backpressure, skew/deskew and double-buffered weights.
module sa_stream_array
  import sa_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter bit SAT  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_w_vld,
  output logic               o_w_rdy,
  input  logic [COLS*DW-1:0] i_w_row,
  input  logic               i_a_vld,
  output logic               o_a_rdy,
  input  logic [ROWS*DW-1:0] i_a_row,
  input  logic               i_a_last,
  output logic               o_c_vld,
  input  logic               i_c_rdy,
  output logic [COLS*DW-1:0] o_c_row,
  output logic               o_c_last,
  output logic               o_busy
);
  localparam int AW     = 2*DW + $clog2(ROWS) + 1;
  localparam int STAGES = ROWS + COLS;
  localparam int RCW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FCW    = $clog2(STAGES + 2);

  logic en, a_acc, w_acc, c_hs, swap;
  logic init_q, shadow_full, active_valid, batch_closed;
  logic [RCW-1:0]                 w_cnt;
  logic [FCW-1:0]                 inflight;
  logic [ROWS-1:0][COLS*DW-1:0]   shadow;
  logic [STAGES:1]                vld_pipe, last_pipe;
  logic [ROWS-1:0][COLS:0][DW-1:0] a_h;
  logic [ROWS:0][COLS-1:0][AW-1:0] p_v;
  logic [COLS-1:0][DW-1:0]        c_dsk;

  assign en      = !(o_c_vld && !i_c_rdy);
  assign o_a_rdy = en && active_valid && !batch_closed;
  assign o_w_rdy = init_q && !shadow_full;
  assign a_acc   = i_a_vld && o_a_rdy;
  assign w_acc   = i_w_vld && o_w_rdy;
  assign c_hs    = o_c_vld && i_c_rdy;
  // Swap requires shadow_full while loading requires !shadow_full, so they never coincide.
  assign swap    = shadow_full && (!active_valid || (batch_closed && inflight == '0));
  assign o_busy  = (inflight != '0);
  assign o_c_vld  = vld_pipe[STAGES];
  assign o_c_last = last_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= 1'b0;
      shadow_full  <= 1'b0;
      active_valid <= 1'b0;
      batch_closed <= 1'b0;
      w_cnt        <= '0;
      inflight     <= '0;
      shadow       <= '0;
    end else begin
      init_q <= 1'b1;
      if (w_acc) begin
        shadow[w_cnt] <= i_w_row;
        if (w_cnt == RCW'(ROWS-1)) begin
          w_cnt       <= '0;
          shadow_full <= 1'b1;
        end else begin
          w_cnt <= w_cnt + 1'b1;
        end
      end
      if (swap) begin
        shadow_full  <= 1'b0;
        active_valid <= 1'b1;
        batch_closed <= 1'b0;
      end else if (a_acc && i_a_last) begin
        batch_closed <= 1'b1;
      end
      case ({a_acc, c_hs})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], a_acc};
      last_pipe <= {last_pipe[STAGES-1:1], a_acc && i_a_last};
    end
  end

  // Input skew: element k waits k enabled cycles before entering row k.
  for (genvar k = 0; k < ROWS; k++) begin : g_skew
    logic [DW-1:0] a_k;
    assign a_k = a_acc ? i_a_row[k*DW +: DW] : '0;
    if (k == 0) begin : g_direct
      assign a_h[0][0] = a_k;
    end else begin : g_sr
      logic [k-1:0][DW-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else if (en) begin
          sr[0] <= a_k;
          for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
        end
      end
      assign a_h[k][0] = sr[k-1];
    end
  end

  assign p_v[0] = '0;

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    for (genvar n = 0; n < COLS; n++) begin : g_col
      sa_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .w_load   (swap),
        .w_in     (shadow[k][n*DW +: DW]),
        .a_in     (a_h[k][n]),
        .psum_in  (p_v[k][n]),
        .a_out    (a_h[k][n+1]),
        .psum_out (p_v[k+1][n])
      );
    end
  end

  // Clamp/wrap before deskew so the delay lines only carry DW bits.
  for (genvar n = 0; n < COLS; n++) begin : g_dsk
    logic [DW-1:0] c_n;
    assign c_n = DW'(sat_f(64'($signed(p_v[ROWS][n])), DW, SAT));
    if (n == COLS-1) begin : g_nodly
      assign c_dsk[n] = c_n;
    end else begin : g_dly
      localparam int D = COLS - 1 - n;
      logic [D-1:0][DW-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else if (en) begin
          sr[0] <= c_n;
          for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
        end
      end
      assign c_dsk[n] = sr[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  o_c_row <= '0;
    else if (en) o_c_row <= c_dsk;
  end
endmodule

// File: tb/tb_sa_stream_array.sv
// Directed + randomized scoreboard bench for sa_stream_array (3x3 saturate, 3x3 wrap, 4x2 random).
module tb_sa_stream_array;
  typedef struct {
    logic [127:0] row;
    logic         last;
    int           stamp;
  } exp_t;

  localparam int LAT_S = 6;
  localparam int LAT_R = 6;

  logic clk, rst_n;
  logic w_vld, a_vld, a_last, c_rdy;
  logic [47:0] w_row, a_row;
  logic s_w_rdy, s_a_rdy, s_c_vld, s_c_last, s_busy;
  logic x_w_rdy, x_a_rdy, x_c_vld, x_c_last, x_busy;
  logic [47:0] s_c_row, x_c_row;
  logic r_w_vld, r_a_vld, r_a_last, r_c_rdy;
  logic [63:0] r_w_row, r_a_row;
  logic r_w_rdy, r_a_rdy, r_c_vld, r_c_last, r_busy;
  logic [31:0] r_c_row;

  int checks = 0, fails = 0;
  int en_cnt_s = 0, en_cnt_r = 0;
  logic en_s_q = 1'b1, en_r_q = 1'b1;
  exp_t q_s[$], q_x[$], q_r[$];
  int mw[4][4];
  int W  [4][4] = '{'{1,2,3,0}, '{4,5,6,0}, '{7,8,9,0}, '{0,0,0,0}};
  int IM [4][4] = '{'{1,0,0,0}, '{0,1,0,0}, '{0,0,1,0}, '{0,0,0,0}};
  int H  [4][4] = '{'{100,100,100,0}, '{100,100,100,0}, '{100,100,100,0}, '{0,0,0,0}};
  int rw [4][4];
  bit done6 = 1'b0;

  sa_stream_array #(.DW(16), .ROWS(3), .COLS(3), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_w_vld(w_vld), .o_w_rdy(s_w_rdy), .i_w_row(w_row),
    .i_a_vld(a_vld), .o_a_rdy(s_a_rdy), .i_a_row(a_row), .i_a_last(a_last),
    .o_c_vld(s_c_vld), .i_c_rdy(c_rdy), .o_c_row(s_c_row), .o_c_last(s_c_last), .o_busy(s_busy));

  sa_stream_array #(.DW(16), .ROWS(3), .COLS(3), .SAT(1'b0)) dut_x (
    .clk(clk), .rst_n(rst_n), .i_w_vld(w_vld), .o_w_rdy(x_w_rdy), .i_w_row(w_row),
    .i_a_vld(a_vld), .o_a_rdy(x_a_rdy), .i_a_row(a_row), .i_a_last(a_last),
    .o_c_vld(x_c_vld), .i_c_rdy(c_rdy), .o_c_row(x_c_row), .o_c_last(x_c_last), .o_busy(x_busy));

  sa_stream_array #(.DW(16), .ROWS(4), .COLS(2), .SAT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .i_w_vld(r_w_vld), .o_w_rdy(r_w_rdy), .i_w_row(r_w_row),
    .i_a_vld(r_a_vld), .o_a_rdy(r_a_rdy), .i_a_row(r_a_row), .i_a_last(r_a_last),
    .o_c_vld(r_c_vld), .i_c_rdy(r_c_rdy), .o_c_row(r_c_row), .o_c_last(r_c_last), .o_busy(r_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(input int rows, input int cols, input bit sat,
                                         input logic [127:0] a, input int w[4][4]);
    logic [127:0] r;
    longint s;
    r = '0;
    for (int n = 0; n < cols; n++) begin
      s = 0;
      for (int k = 0; k < rows; k++) s += longint'($signed(a[k*16 +: 16])) * longint'(w[k][n]);
      if (sat) begin
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
      end
      r[n*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [47:0] pk(input int e0, input int e1, input int e2);
    return {16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // Enabled-cycle counters for latency stamps.
  always @(negedge clk) begin
    en_s_q = !(s_c_vld && !c_rdy);
    en_r_q = !(r_c_vld && !r_c_rdy);
  end
  always @(posedge clk) begin
    if (rst_n && en_s_q) en_cnt_s++;
    if (rst_n && en_r_q) en_cnt_r++;
  end

  always @(negedge clk) if (rst_n && s_c_vld && c_rdy) begin
    exp_t e;
    chk("s_spurious", 128'(q_s.size() != 0), 128'(1));
    if (q_s.size() != 0) begin
      e = q_s.pop_front();
      chk("s_row", 128'(s_c_row), e.row);
      chk("s_last", 128'(s_c_last), 128'(e.last));
      chk("s_latency", 128'(en_cnt_s - e.stamp), 128'(LAT_S));
    end
  end

  always @(negedge clk) if (rst_n && x_c_vld && c_rdy) begin
    exp_t e;
    chk("x_spurious", 128'(q_x.size() != 0), 128'(1));
    if (q_x.size() != 0) begin
      e = q_x.pop_front();
      chk("x_row", 128'(x_c_row), e.row);
      chk("x_last", 128'(x_c_last), 128'(e.last));
    end
  end

  always @(negedge clk) if (rst_n && r_c_vld && r_c_rdy) begin
    exp_t e;
    chk("r_spurious", 128'(q_r.size() != 0), 128'(1));
    if (q_r.size() != 0) begin
      e = q_r.pop_front();
      chk("r_row", 128'(r_c_row), e.row);
      chk("r_last", 128'(r_c_last), 128'(e.last));
      chk("r_latency", 128'(en_cnt_r - e.stamp), 128'(LAT_R));
    end
  end

  task automatic load_w(input logic [47:0] row);
    int t = 0;
    w_vld = 1'b1; w_row = row;
    @(negedge clk);
    while (!s_w_rdy && t < 200) begin @(negedge clk); t++; end
    chk("w_accept", 128'(s_w_rdy), 128'(1));
    @(posedge clk); #1;
    w_vld = 1'b0;
  endtask

  task automatic load_w3(input int m[4][4]);
    for (int k = 0; k < 3; k++) load_w(pk(m[k][0], m[k][1], m[k][2]));
  endtask

  task automatic send_a(input logic [47:0] row, input logic last, input bit chk_drained);
    int t = 0;
    exp_t e;
    a_vld = 1'b1; a_row = row; a_last = last;
    @(negedge clk);
    while (!s_a_rdy && t < 200) begin @(negedge clk); t++; end
    chk("a_accept", 128'(s_a_rdy), 128'(1));
    if (s_a_rdy) begin
      if (chk_drained) chk("swap_after_drain", 128'(q_s.size()), 128'(0));
      e.row = model(3, 3, 1'b1, 128'(row), mw); e.last = last; e.stamp = en_cnt_s;
      q_s.push_back(e);
      e.row = model(3, 3, 1'b0, 128'(row), mw);
      q_x.push_back(e);
    end
    @(posedge clk); #1;
    a_vld = 1'b0; a_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (s_busy && t < 300) begin @(posedge clk); #1; t++; end
    chk({tag, "_drain"}, 128'(s_busy), 128'(0));
    chk({tag, "_queue"}, 128'(q_s.size() + q_x.size()), 128'(0));
  endtask

  initial begin
    int t, stale;
    logic [15:0] v;
    exp_t e;
    rst_n = 1'b0; w_vld = 1'b0; a_vld = 1'b0; a_last = 1'b0; c_rdy = 1'b1;
    w_row = '0; a_row = '0;
    r_w_vld = 1'b0; r_a_vld = 1'b0; r_a_last = 1'b0; r_c_rdy = 1'b1; r_w_row = '0; r_a_row = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_rdy", 128'(s_w_rdy), 128'(0));
    chk("rst_a_rdy", 128'(s_a_rdy), 128'(0));
    chk("rst_c_vld", 128'(s_c_vld), 128'(0));
    chk("rst_busy",  128'(s_busy),  128'(0));
    chk("rst_c_row", 128'(s_c_row), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("w_rdy_after_rst", 128'(s_w_rdy), 128'(1));
    chk("a_rdy_no_weights", 128'(s_a_rdy), 128'(0));

    // Basic 3x3 batch.
    mw = W;
    load_w3(W);
    send_a(pk(1,2,3), 1'b0, 1'b0);
    send_a(pk(4,5,6), 1'b0, 1'b0);
    send_a(pk(7,8,9), 1'b1, 1'b0);
    wait_idle("t1");

    // Downstream stall holds the first C row and blocks A.
    load_w3(W);
    send_a(pk(1,2,3), 1'b0, 1'b0);
    send_a(pk(4,5,6), 1'b0, 1'b0);
    t = 0;
    while (!s_c_vld && t < 50) begin @(posedge clk); #1; t++; end
    chk("t2_first_vld", 128'(s_c_vld), 128'(1));
    c_rdy = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t2_hold_vld", 128'(s_c_vld), 128'(1));
      chk("t2_hold_row", 128'(s_c_row), 128'(pk(30,36,42)));
      chk("t2_a_blocked", 128'(s_a_rdy), 128'(0));
    end
    c_rdy = 1'b1;
    send_a(pk(7,8,9), 1'b1, 1'b0);
    wait_idle("t2");

    // Shadow reload while batch 1 streams; batch 2 waits for drain.
    load_w3(W);
    send_a(pk(1,2,3), 1'b0, 1'b0);
    load_w(pk(1,0,0));
    send_a(pk(4,5,6), 1'b0, 1'b0);
    load_w(pk(0,1,0));
    send_a(pk(7,8,9), 1'b1, 1'b0);
    load_w(pk(0,0,1));
    chk("t3_shadow_full", 128'(s_w_rdy), 128'(0));
    chk("t3_batch_closed", 128'(s_a_rdy), 128'(0));
    chk("t3_busy", 128'(s_busy), 128'(1));
    mw = IM;
    send_a(pk(-1,2,-3), 1'b1, 1'b1);
    wait_idle("t3");

    // Saturate vs wrap.
    mw = H;
    load_w3(H);
    send_a(pk(1000,1000,1000), 1'b0, 1'b0);
    send_a(pk(-1000,-1000,-1000), 1'b1, 1'b0);
    wait_idle("t4");

    // Reset with rows in flight.
    mw = W;
    load_w3(W);
    send_a(pk(1,2,3), 1'b0, 1'b0);
    send_a(pk(4,5,6), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_c_vld", 128'(s_c_vld), 128'(0));
    chk("t5_a_rdy", 128'(s_a_rdy), 128'(0));
    chk("t5_w_rdy", 128'(s_w_rdy), 128'(0));
    chk("t5_busy",  128'(s_busy),  128'(0));
    chk("t5_c_row", 128'(s_c_row), 128'(0));
    chk("t5_x_c_vld", 128'(x_c_vld), 128'(0));
    q_s.delete(); q_x.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_w_rdy_after", 128'(s_w_rdy), 128'(1));
    chk("t5_a_rdy_after", 128'(s_a_rdy), 128'(0));
    stale = 0;
    repeat (12) begin @(posedge clk); #1; if (s_c_vld || x_c_vld) stale++; end
    chk("t5_no_stale", 128'(stale), 128'(0));
    load_w(pk(1,2,3));
    load_w(pk(4,5,6));
    chk("t5_a_rdy_partial", 128'(s_a_rdy), 128'(0));
    load_w(pk(7,8,9));
    send_a(pk(2,0,-1), 1'b1, 1'b0);
    wait_idle("t5");

    // 4x2 random traffic with random A gaps and C backpressure.
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          for (int n = 0; n < 2; n++) begin
            rw[k][n] = int'($urandom_range(0, 600)) - 300;
            r_w_row[n*16 +: 16] = 16'(rw[k][n]);
          end
          rw[k][2] = 0; rw[k][3] = 0;
          r_w_vld = 1'b1;
          t = 0;
          @(negedge clk);
          while (!r_w_rdy && t < 200) begin @(negedge clk); t++; end
          chk("r_w_accept", 128'(r_w_rdy), 128'(1));
          @(posedge clk); #1;
          r_w_vld = 1'b0;
        end
        for (int i = 0; i < 24; i++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          for (int k = 0; k < 4; k++) begin
            if (i % 5 == 4) v = 16'($urandom);
            else v = 16'(int'($urandom_range(0, 400)) - 200);
            r_a_row[k*16 +: 16] = v;
          end
          r_a_vld = 1'b1; r_a_last = (i == 23);
          t = 0;
          @(negedge clk);
          while (!r_a_rdy && t < 200) begin @(negedge clk); t++; end
          chk("r_a_accept", 128'(r_a_rdy), 128'(1));
          if (r_a_rdy) begin
            e.row = model(4, 2, 1'b1, 128'(r_a_row), rw); e.last = r_a_last; e.stamp = en_cnt_r;
            q_r.push_back(e);
          end
          @(posedge clk); #1;
          r_a_vld = 1'b0; r_a_last = 1'b0;
        end
        t = 0;
        while (r_busy && t < 500) begin @(posedge clk); #1; t++; end
        chk("r_drain", 128'(r_busy), 128'(0));
        chk("r_queue", 128'(q_r.size()), 128'(0));
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk); #1;
          r_c_rdy = ($urandom_range(0, 3) != 0);
        end
        r_c_rdy = 1'b1;
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end
endmodule
